proc_ctrl: RTL

- Control sequencer for the 9-bit datapath.
- Fetches a 9-bit instruction from DIN, decodes it, and drives the one-hot register write and bus-select strobes that feed the general registers, the A/G registers and the ALU.
- Sits directly upstream of the register file; every register load enable in the datapath originates here.
- Multi-cycle, one instruction at a time, started by Run, completed by Done.

---
 rtl/proc_pkg.sv | 52 +++++
 rtl/proc_ctrl_if.sv | 27 ++
 rtl/dec3to8.sv | 18 +
 rtl/proc_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the proc_ctrl sequencer: opcodes, ALU codes, state encoding.
// Opcode 100 decoding depends on the PROC_CTRL_XOR_EN macro.
package proc_pkg;

    localparam int DW   = 9;
    localparam int NREG = 8;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_XOR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4
    } state_t;

    // True for opcodes that run the T1..T3 ALU sequence.
    function automatic logic is_alu_op(input logic [2:0] op);
        logic res;
        case (op)
            OP_ADD:  res = 1'b1;
            OP_SUB:  res = 1'b1;
`ifdef PROC_CTRL_XOR_EN
            OP_XOR:  res = 1'b1;
`endif
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic [1:0] alu_code(input logic [2:0] op);
        logic [1:0] res;
        case (op)
            OP_SUB:  res = ALU_SUB;
`ifdef PROC_CTRL_XOR_EN
            OP_XOR:  res = ALU_XOR;
`endif
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/proc_ctrl_if.sv
// Control bus between the proc_ctrl sequencer (master) and the datapath (slave).
interface proc_ctrl_if #(
    parameter int DW   = 9,
    parameter int NREG = 8
);
    logic            Run;
    logic [DW-1:0]   DIN;
    logic [NREG-1:0] R_in;
    logic [NREG-1:0] R_out;
    logic            DIN_out;
    logic            A_in;
    logic            G_in;
    logic            G_out;
    logic [1:0]      alu_op;
    logic            Done;
    logic            Busy;

    modport master (
        input  Run, DIN,
        output R_in, R_out, DIN_out, A_in, G_in, G_out, alu_op, Done, Busy
    );

    modport slave (
        output Run, DIN,
        input  R_in, R_out, DIN_out, A_in, G_in, G_out, alu_op, Done, Busy
    );
endinterface

// File: rtl/dec3to8.sv
// Combinational 3-to-8 one-hot decoder with enable.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] onehot
);

    // One-hot decode of sel, all zeros when disabled.
    always_comb begin
        onehot = 8'h00;
        if (en) begin
            onehot[sel] = 1'b1;
        end else begin
            onehot = 8'h00;
        end
    end

endmodule

// File: rtl/proc_ctrl.sv
// Multi-cycle control sequencer for the 9-bit datapath (mv, mvi, add, sub, optional xor).
// Define PROC_CTRL_XOR_EN to decode opcode 100 as xor; otherwise it is a nop.
module proc_ctrl
    import proc_pkg::*;
#(
    parameter int DW   = 9,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          Reset,
    proc_ctrl_if.master   bus
);

    state_t        state_r;
    state_t        state_s;
    logic [DW-1:0] ir_r;

    logic [2:0] op_s;
    logic [2:0] x_s;
    logic [2:0] y_s;

    logic       rin_en_s;
    logic       rout_x_s;
    logic       rout_y_s;
    logic       din_out_s;
    logic       a_in_s;
    logic       g_in_s;
    logic       g_out_s;
    logic [1:0] alu_op_s;
    logic       done_s;
    logic       busy_s;

    logic       rout_en_s;
    logic [2:0] rout_sel_s;
    logic [7:0] rin_hot_s;
    logic [7:0] rout_hot_s;

    assign op_s = ir_r[8:6];
    assign x_s  = ir_r[5:3];
    assign y_s  = ir_r[2:0];

    // State register and instruction register; IR loads only at the end of T0.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r <= S_IDLE;
            ir_r    <= '0;
        end else begin
            state_r <= state_s;
            if (state_r == S_T0) begin
                ir_r <= bus.DIN;
            end else begin
                ir_r <= ir_r;
            end
        end
    end

    // Next-state logic; Run is only looked at in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.Run) begin
                    state_s = S_T0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_T0: state_s = S_T1;
            S_T1: begin
                if (is_alu_op(op_s)) begin
                    state_s = S_T2;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_T2:    state_s = S_T3;
            S_T3:    state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Strobe generation; Reset blanks every output in the cycle it is asserted.
    always_comb begin
        rin_en_s  = 1'b0;
        rout_x_s  = 1'b0;
        rout_y_s  = 1'b0;
        din_out_s = 1'b0;
        a_in_s    = 1'b0;
        g_in_s    = 1'b0;
        g_out_s   = 1'b0;
        alu_op_s  = ALU_ADD;
        done_s    = 1'b0;
        busy_s    = 1'b0;
        if (Reset) begin
            busy_s = 1'b0;
        end else begin
            busy_s = (state_r != S_IDLE);
            case (state_r)
                S_T1: begin
                    if (is_alu_op(op_s)) begin
                        rout_x_s = 1'b1;
                        a_in_s   = 1'b1;
                    end else if (op_s == OP_MV) begin
                        rout_y_s = 1'b1;
                        rin_en_s = 1'b1;
                        done_s   = 1'b1;
                    end else if (op_s == OP_MVI) begin
                        din_out_s = 1'b1;
                        rin_en_s  = 1'b1;
                        done_s    = 1'b1;
                    end else begin
                        done_s = 1'b1;
                    end
                end
                S_T2: begin
                    rout_y_s = 1'b1;
                    g_in_s   = 1'b1;
                    alu_op_s = alu_code(op_s);
                end
                S_T3: begin
                    g_out_s  = 1'b1;
                    rin_en_s = 1'b1;
                    done_s   = 1'b1;
                end
                default: begin
                    done_s = 1'b0;
                end
            endcase
        end
    end

    // R_out draws from X in T1 of an ALU op and from Y otherwise, so its decoder select is muxed.
    assign rout_en_s  = rout_x_s | rout_y_s;
    assign rout_sel_s = rout_x_s ? x_s : y_s;

    dec3to8 u_dec_rin (
        .en     (rin_en_s),
        .sel    (x_s),
        .onehot (rin_hot_s)
    );

    dec3to8 u_dec_rout (
        .en     (rout_en_s),
        .sel    (rout_sel_s),
        .onehot (rout_hot_s)
    );

    assign bus.R_in    = rin_hot_s;
    assign bus.R_out   = rout_hot_s;
    assign bus.DIN_out = din_out_s;
    assign bus.A_in    = a_in_s;
    assign bus.G_in    = g_in_s;
    assign bus.G_out   = g_out_s;
    assign bus.alu_op  = alu_op_s;
    assign bus.Done    = done_s;
    assign bus.Busy    = busy_s;

endmodule
